// File: rtl/word_adder_pkg.sv
// Shared word-level definitions for the datapath adder and its CLA slices.
package word_adder_pkg;

  localparam int WORD_W  = 32;
  localparam int SLICE_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  // Two's-complement overflow: like-signed operands producing an opposite-signed result.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/word_adder_cla4_slice.sv
// 4-bit carry-lookahead slice: all internal carries are formed in parallel from
// the bit generate/propagate terms; group P/G are exported for a future
// two-level lookahead tree.
module cla4_slice
  import word_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               grp_p,
  output logic               grp_g
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  // Bit generate/propagate, flattened lookahead carries, and sum bits.
  always_comb begin
    g = a & b;
    p = a ^ b;

    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);

    s     = p ^ c[SLICE_W-1:0];
    cout  = c[4];
    grp_p = &p;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/word_adder.sv
// Word adder for PC increment / branch targets: combinational sum, carry and
// signed overflow, plus a registered status copy for debug/trace.
module word_adder
  import word_adder_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  output logic [WIDTH-1:0] add_out,
  output logic             carry,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             ovf_q
);

  localparam int NSLICE = WIDTH / SLICE_W;

  // Carry into each slice; slice_c[NSLICE] is the carry-out of the MSB.
  logic [NSLICE:0]   slice_c;
  // Group terms are kept for a later two-level lookahead; the ripple uses cout.
  logic [NSLICE-1:0] unused_grp_p;
  logic [NSLICE-1:0] unused_grp_g;

  assign slice_c[0] = 1'b0;

  // Ripple the slice carries; each slice resolves its own bits in parallel.
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    cla4_slice u_slice (
      .a     (add_in1[i*SLICE_W +: SLICE_W]),
      .b     (add_in2[i*SLICE_W +: SLICE_W]),
      .cin   (slice_c[i]),
      .s     (add_out[i*SLICE_W +: SLICE_W]),
      .cout  (slice_c[i+1]),
      .grp_p (unused_grp_p[i]),
      .grp_g (unused_grp_g[i])
    );
  end

  // Unsigned carry-out and signed overflow from the final slice and the MSBs.
  always_comb begin
    carry = slice_c[NSLICE];
    ovf   = signed_ovf(add_in1[WIDTH-1], add_in2[WIDTH-1], add_out[WIDTH-1]);
  end

  // Status capture stage: one-cycle copy of the combinational results.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sum_q   <= add_out;
      carry_q <= carry;
      ovf_q   <= ovf;
    end
  end

endmodule

// File: tb/tb_word_adder.sv
// Directed bench for word_adder: combinational results, registered copy,
// reset behaviour, plus a random sweep against a behavioural adder.
module tb_word_adder;

  logic        clk;
  logic        rst;
  logic [31:0] add_in1;
  logic [31:0] add_in2;
  logic [31:0] add_out;
  logic        carry;
  logic        ovf;
  logic [31:0] sum_q;
  logic        carry_q;
  logic        ovf_q;

  int tests;
  int fails;

  word_adder #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .add_in1 (add_in1),
    .add_in2 (add_in2),
    .add_out (add_out),
    .carry   (carry),
    .ovf     (ovf),
    .sum_q   (sum_q),
    .carry_q (carry_q),
    .ovf_q   (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag, input logic [31:0] s, input logic c, input logic o);
    chk({tag, ".add_out"}, add_out, s);
    chk({tag, ".carry"}, {31'd0, carry}, {31'd0, c});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, o});
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] s, input logic c, input logic o);
    chk({tag, ".sum_q"}, sum_q, s);
    chk({tag, ".carry_q"}, {31'd0, carry_q}, {31'd0, c});
    chk({tag, ".ovf_q"}, {31'd0, ovf_q}, {31'd0, o});
  endtask

  // Drive a pair just after a rising edge, let it settle 2 ns, then check.
  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    add_in1 = a;
    add_in2 = b;
    #2;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] ref_sum;
    logic        ref_ovf;
    tests = 0;
    fails = 0;
    rst     = 1'b1;
    add_in1 = 32'd0;
    add_in2 = 32'd0;

    // Combinational outputs are valid before any clock edge, even in reset.
    #1;
    chk_comb("zeros", 32'd0, 1'b0, 1'b0);

    next_edge();
    chk_reg("reset", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic sum and one-cycle registered copy.
    apply(32'd5, 32'd12);
    chk_comb("basic", 32'd17, 1'b0, 1'b0);
    next_edge();
    chk_reg("basic_q", 32'd17, 1'b0, 1'b0);

    // Unsigned wrap.
    apply(32'hFFFF_FFFF, 32'h0000_0001);
    chk_comb("wrap", 32'h0000_0000, 1'b1, 1'b0);
    next_edge();
    chk_reg("wrap_q", 32'h0000_0000, 1'b1, 1'b0);

    // Signed overflow, positive direction.
    apply(32'h7FFF_FFFF, 32'h0000_0001);
    chk_comb("ovf_pos", 32'h8000_0000, 1'b0, 1'b1);
    next_edge();
    chk_reg("ovf_pos_q", 32'h8000_0000, 1'b0, 1'b1);

    // Signed overflow, negative direction with carry.
    apply(32'h8000_0000, 32'h8000_0000);
    chk_comb("ovf_neg", 32'h0000_0000, 1'b1, 1'b1);
    next_edge();
    chk_reg("ovf_neg_q", 32'h0000_0000, 1'b1, 1'b1);

    // Slice boundary crossings.
    apply(32'h0000_000F, 32'h0000_0001);
    chk_comb("slice1", 32'h0000_0010, 1'b0, 1'b0);
    apply(32'h0FFF_FFFF, 32'h0000_0001);
    chk_comb("slice7", 32'h1000_0000, 1'b0, 1'b0);
    apply(32'h0000_FFFF, 32'h0000_FFFF);
    chk_comb("half", 32'h0001_FFFE, 1'b0, 1'b0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_comb("allones", 32'hFFFF_FFFE, 1'b1, 1'b0);
    apply(32'h1234_5678, 32'h1111_1111);
    chk_comb("mixed", 32'h2345_6789, 1'b0, 1'b0);

    // Reset mid-stream clears only the registered copy.
    apply(32'd5, 32'd12);
    next_edge();
    chk_reg("pre_rst_q", 32'd17, 1'b0, 1'b0);
    rst = 1'b1;
    next_edge();
    chk_reg("rst_q", 32'd0, 1'b0, 1'b0);
    chk_comb("rst_comb", 32'd17, 1'b0, 1'b0);
    rst = 1'b0;
    next_edge();
    chk_reg("post_rst_q", 32'd17, 1'b0, 1'b0);

    // Random pairs against a behavioural 33-bit sum.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      add_in1 = ra;
      add_in2 = rb;
      #1;
      ref_sum = {1'b0, ra} + {1'b0, rb};
      ref_ovf = (ra[31] == rb[31]) && (ref_sum[31] != ra[31]);
      tests++;
      assert ({carry, ovf, add_out} === {ref_sum[32], ref_ovf, ref_sum[31:0]}) else begin
        fails++;
        $error("FAIL rand a=%h b=%h observed=%b/%b/%h expected=%b/%b/%h",
               ra, rb, carry, ovf, add_out, ref_sum[32], ref_ovf, ref_sum[31:0]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
